// File: rtl/inst_fetch_buf.sv
// Instruction fetch unit with prefetch FIFO.
// Fetches 32-bit words from instruction ROM over a req/ack handshake with one
// request outstanding. Buffers up to DEPTH {addr,inst} pairs for the decode
// stage. A redirect from ex flushes the FIFO and restarts fetch at the target.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | no request outstanding; issue when FIFO has room and no redirect
// WAIT    | request outstanding; push the returned word on ack
// DISCARD | request outstanding but redirected; drop the word on ack
module inst_fetch_buf #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rom_req_o,
   output logic [31:0] rom_addr_o,
   input  logic        rom_ack_i,
   input  logic [31:0] rom_rdata_i,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
);

   localparam int          AW   = $clog2(DEPTH);
   localparam int          CW   = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   req_addr;
   logic [31:0]   fetch_pc;
   logic [31:0]   jump_tgt;
   logic [31:0]   mem_addr [DEPTH];
   logic [31:0]   mem_inst [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          issue;
   logic          push;
   logic          pop;

   // Redirect target is always word aligned.
   assign jump_tgt     = jump_addr_i & ~32'h0000_0003;

   assign rom_req_o    = (state != IDLE);
   assign rom_addr_o   = req_addr;
   assign inst_valid_o = (count != '0);
   assign inst_o       = inst_valid_o ? mem_inst[rd_ptr] : NOP;
   assign inst_addr_o  = inst_valid_o ? mem_addr[rd_ptr] : 32'h0000_0000;

   // A redirect steals the pop so the flushed head is never credited.
   assign pop          = inst_valid_o && !hold_i && !jump_en_i;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and issue/push decode.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if (!jump_en_i && (count < FULL)) begin
               issue     = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (rom_ack_i) begin
               push      = !jump_en_i;
               state_nxt = IDLE;
            end else if (jump_en_i) begin
               state_nxt = DISCARD;
            end
         end
         DISCARD: begin
            if (rom_ack_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Fetch PC, request address, FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_addr <= RESET_PC;
         fetch_pc <= RESET_PC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (issue) req_addr <= fetch_pc;
         if (jump_en_i) begin
            fetch_pc <= jump_tgt;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
         end else begin
            if (push) begin
               fetch_pc <= fetch_pc + 32'd4;
               wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // FIFO storage; contents are masked at the outputs when empty, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr] <= req_addr;
         mem_inst[wr_ptr] <= rom_rdata_i;
      end
   end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf: inputs driven and outputs sampled 1ns
// after the rising edge; an optional zero-wait ROM answers inside tick().
module tb_inst_fetch_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_req_o;
   logic [31:0] rom_addr_o;
   logic        rom_ack_i;
   logic [31:0] rom_rdata_i;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;

   int total = 0;
   int bad   = 0;
   bit auto_ack;

   localparam logic [31:0] NOP = 32'h0000_0013;

   inst_fetch_buf #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .rom_req_o    (rom_req_o),
      .rom_addr_o   (rom_addr_o),
      .rom_ack_i    (rom_ack_i),
      .rom_rdata_i  (rom_rdata_i),
      .jump_en_i    (jump_en_i),
      .jump_addr_i  (jump_addr_i),
      .hold_i       (hold_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_addr_o  (inst_addr_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] romf(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_ack) begin
         rom_ack_i   = rom_req_o;
         rom_rdata_i = rom_req_o ? romf(rom_addr_o) : 32'h0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
      chk({tag, "_inst"}, inst_o, NOP);
      chk({tag, "_addr"}, inst_addr_o, 32'h0);
   endtask

   initial begin
      rst         = 1'b1;
      rom_ack_i   = 1'b0;
      rom_rdata_i = 32'h0;
      jump_en_i   = 1'b0;
      jump_addr_i = 32'h0;
      hold_i      = 1'b0;
      auto_ack    = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_req", 32'(rom_req_o), 32'd0);
      chk("rst_raddr", rom_addr_o, 32'h0);
      chk_empty("rst");
      rst = 1'b0;

      // 1: sequential fetch, zero-wait ROM, no hold
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t1_req", 32'(rom_req_o), 32'd1);
         chk("t1_raddr", rom_addr_o, 32'(4 * k));
         chk_empty("t1_gap");
         tick();
         chk("t1_valid", 32'(inst_valid_o), 32'd1);
         chk("t1_addr", inst_addr_o, 32'(4 * k));
         chk("t1_inst", inst_o, romf(32'(4 * k)));
      end

      // 2: hold until full (leftover 0xC plus 0x10,0x14,0x18)
      hold_i = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      chk("t2_full_addr", inst_addr_o, 32'hC);
      chk("t2_full_req", 32'(rom_req_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t2_stall_req", 32'(rom_req_o), 32'd0);
         chk("t2_stall_cnt", 32'(dut.count), 32'd4);
      end
      hold_i = 1'b0;
      tick();
      chk("t2_pop0", inst_addr_o, 32'h10);
      chk("t2_pop0_req", 32'(rom_req_o), 32'd0);
      tick();
      chk("t2_pop1", inst_addr_o, 32'h14);
      chk("t2_resume_req", 32'(rom_req_o), 32'd1);
      chk("t2_resume_raddr", rom_addr_o, 32'h1C);
      tick();
      chk("t2_pop2", inst_addr_o, 32'h18);
      chk("t2_pop2_inst", inst_o, romf(32'h18));
      tick();
      chk("t2_pop3", inst_addr_o, 32'h1C);

      // 3: redirect while WAIT, ack arrives 3 cycles after the jump
      do_reset();
      auto_ack  = 1'b0;
      rom_ack_i = 1'b0;
      tick();
      chk("t3_req", 32'(rom_req_o), 32'd1);
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_0102;
      tick();
      jump_en_i = 1'b0;
      chk("t3_disc_req", 32'(rom_req_o), 32'd1);
      chk("t3_disc_raddr", rom_addr_o, 32'h0);
      chk_empty("t3_flush");
      tick();
      tick();
      chk("t3_hold_raddr", rom_addr_o, 32'h0);
      rom_ack_i   = 1'b1;
      rom_rdata_i = 32'hDEAD_BEEF;
      auto_ack    = 1'b1;
      tick();
      chk("t3_drop_req", 32'(rom_req_o), 32'd0);
      chk_empty("t3_drop");
      tick();
      chk("t3_new_raddr", rom_addr_o, 32'h100);
      chk("t3_new_req", 32'(rom_req_o), 32'd1);
      hold_i = 1'b1;
      tick();
      chk("t3_new_addr", inst_addr_o, 32'h100);
      chk("t3_new_inst", inst_o, romf(32'h100));

      // 4: jump coincident with ack and a would-be pop
      tick();
      chk("t4_req", 32'(rom_req_o), 32'd1);
      chk("t4_raddr", rom_addr_o, 32'h104);
      chk("t4_ack", 32'(rom_ack_i), 32'd1);
      hold_i      = 1'b0;
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_0203;
      tick();
      jump_en_i = 1'b0;
      chk("t4_req_off", 32'(rom_req_o), 32'd0);
      chk("t4_cnt", 32'(dut.count), 32'd0);
      chk_empty("t4_flush");
      tick();
      chk("t4_new_raddr", rom_addr_o, 32'h200);
      tick();
      chk("t4_new_addr", inst_addr_o, 32'h200);
      // jump while IDLE: no issue that cycle, target issued next cycle
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_0300;
      tick();
      jump_en_i = 1'b0;
      chk("t4i_req", 32'(rom_req_o), 32'd0);
      chk_empty("t4i_flush");
      tick();
      chk("t4i_req2", 32'(rom_req_o), 32'd1);
      chk("t4i_raddr", rom_addr_o, 32'h300);

      // 5: fill to 2 then push+pop together across pointer wrap
      hold_i = 1'b1;
      tick();
      tick();
      tick();
      chk("t5_cnt_init", 32'(dut.count), 32'd2);
      for (int k = 0; k < 6; k++) begin
         hold_i = 1'b1;
         tick();
         chk("t5_issue_head", inst_addr_o, 32'h300 + 32'(4 * k));
         chk("t5_issue_cnt", 32'(dut.count), 32'd2);
         hold_i = 1'b0;
         tick();
         chk("t5_pp_head", inst_addr_o, 32'h304 + 32'(4 * k));
         chk("t5_pp_inst", inst_o, romf(32'h304 + 32'(4 * k)));
         chk("t5_pp_cnt", 32'(dut.count), 32'd2);
      end

      // 6: reset while WAIT with ROM acking during and after reset
      auto_ack  = 1'b0;
      rom_ack_i = 1'b0;
      hold_i    = 1'b0;
      tick();
      chk("t6_wait_req", 32'(rom_req_o), 32'd1);
      rst         = 1'b1;
      rom_ack_i   = 1'b1;
      rom_rdata_i = 32'hBAD0_BAD0;
      tick();
      chk("t6_rst_req", 32'(rom_req_o), 32'd0);
      chk("t6_rst_raddr", rom_addr_o, 32'h0);
      chk_empty("t6_rst");
      tick();
      rst = 1'b0;
      tick();
      chk("t6_post_req", 32'(rom_req_o), 32'd1);
      chk("t6_post_raddr", rom_addr_o, 32'h0);
      chk("t6_post_cnt", 32'(dut.count), 32'd0);
      chk_empty("t6_post");
      rom_rdata_i = romf(32'h0);
      tick();
      rom_ack_i = 1'b0;
      chk("t6_first_addr", inst_addr_o, 32'h0);
      chk("t6_first_inst", inst_o, romf(32'h0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
